// File: rtl/lcd12864_text_buf.sv
// Purpose : 4x16-byte text frame buffer feeding the LCD12864 driver as DDRAM bytes.
// Latency : first stream beat 1 cycle after STREAM entry; frame_done 1 cycle after last handshake.
// Backpress: valid/ready stream; beat held stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data     random-access write (index = row*16+col)
//   put_en/put_data           write at cursor, cursor auto-increments (mod 64)
//   cur_set/cur_addr          load cursor (with put_en: write at cur_addr, cursor = cur_addr+1)
//   clr_req                   clear-screen request; busy high while clearing
//   frame_req                 stream whole frame over out_* ; frame_done pulses at end
//   out_valid/out_ready/out_data/out_idx/out_rs/out_sof   stream beat interface
//
// Build option: define LCD12864_TEXTBUF_ADDR_CMD_EN to precede each row with a
// DDRAM set-address command beat (out_rs=0), giving a 68-beat frame.
// The index arithmetic below assumes ROWS=4, COLS=16 (64 entries, 6-bit index).

module lcd12864_text_buf #(
    parameter int         ROWS     = 4,
    parameter int         COLS     = 16,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       put_en,
    input  logic [7:0] put_data,
    input  logic       cur_set,
    input  logic [5:0] cur_addr,
    input  logic       clr_req,
    input  logic       frame_req,
    output logic       busy,
    output logic [5:0] cursor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [5:0] out_idx,
    output logic       out_rs,
    output logic       out_sof,
    output logic       frame_done
);

    localparam int         DEPTH    = ROWS * COLS;
    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);
    localparam logic [3:0] ROW_END  = 4'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] mem [DEPTH];

    logic       pend_clr;
    logic       pend_frm;
    logic [5:0] clr_idx;

    // stream loader: next index to fetch, and whether everything is loaded
    logic [5:0] ld_idx;
    logic       ld_done;
    logic       ld_first;

    // control decoded from state
    logic       clr_go;
    logic       frm_go;
    logic       clr_last;
    logic       ld_fire;
    logic       hs;
    logic       last_hs;

    // application writes (dropped while clearing)
    logic       wr_ok;
    logic       put_ok;
    logic [5:0] put_addr;
    logic [7:0] ld_byte;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        clr_go   = 1'b0;
        frm_go   = 1'b0;
        clr_last = 1'b0;
        ld_fire  = 1'b0;
        last_hs  = 1'b0;
        unique case (state)
            IDLE: begin
                // clear always wins over a frame request
                if (clr_req || pend_clr) begin
                    clr_go   = 1'b1;
                    state_nx = CLEAR;
                end else if (frame_req || pend_frm) begin
                    frm_go   = 1'b1;
                    state_nx = STREAM;
                end
            end
            CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    clr_last = 1'b1;
                    state_nx = IDLE;
                end
            end
            STREAM: begin
                ld_fire = !ld_done && (!out_valid || out_ready);
                // ld_done means the beat on the output is the final one
                last_hs = ld_done && out_valid && out_ready;
                if (last_hs) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign hs       = out_valid && out_ready;
    assign wr_ok    = wr_en && !busy;
    assign put_ok   = put_en && !busy;
    assign put_addr = cur_set ? cur_addr : cursor;

    // ------------------------------------------------------------------
    // Request latching: a request that cannot be taken this cycle is held
    // one-deep; repeats merge into the same flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_clr <= 1'b0;
            pend_frm <= 1'b0;
        end else begin
            pend_clr <= clr_go ? 1'b0 : (pend_clr | clr_req);
            pend_frm <= frm_go ? 1'b0 : (pend_frm | frame_req);
        end
    end

    // ------------------------------------------------------------------
    // Text storage. The put write is issued after the random-access write
    // so a same-index collision resolves in favour of put_data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= CLR_CHAR;
            end
        end else if (state == CLEAR) begin
            mem[clr_idx] <= CLR_CHAR;
        end else begin
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
            if (put_ok) begin
                mem[put_addr] <= put_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (clr_go) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 6'd1;
        end
    end

    // ------------------------------------------------------------------
    // Cursor. A finished clear homes it, overriding any same-cycle load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor <= '0;
        end else if (clr_last) begin
            cursor <= '0;
        end else if (put_ok) begin
            cursor <= put_addr + 6'd1;
        end else if (cur_set) begin
            cursor <= cur_addr;
        end
    end

    // ------------------------------------------------------------------
    // Fetch with write bypass: a byte written in the same cycle its index
    // is loaded must reach the stream, since mem updates only at the edge.
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte = mem[ld_idx];
        if (wr_ok && (wr_addr == ld_idx)) begin
            ld_byte = wr_data;
        end
        if (put_ok && (put_addr == ld_idx)) begin
            ld_byte = put_data;
        end
    end

`ifdef LCD12864_TEXTBUF_ADDR_CMD_EN
    logic ld_cmd;
    logic [7:0] row_cmd;

    // ST7920 DDRAM row start addresses: rows 0..3 -> 80, 90, 88, 98
    always_comb begin
        row_cmd = 8'h80;
        unique case (ld_idx[5:4])
            2'd0: row_cmd = 8'h80;
            2'd1: row_cmd = 8'h90;
            2'd2: row_cmd = 8'h88;
            2'd3: row_cmd = 8'h98;
            default: row_cmd = 8'h80;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_rs     <= 1'b1;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            ld_idx     <= '0;
            ld_done    <= 1'b0;
            ld_first   <= 1'b0;
            ld_cmd     <= 1'b0;
        end else begin
            frame_done <= last_hs;
            if (frm_go) begin
                ld_idx   <= '0;
                ld_done  <= 1'b0;
                ld_first <= 1'b1;
                ld_cmd   <= 1'b1;
            end else if (ld_fire) begin
                out_valid <= 1'b1;
                out_idx   <= ld_idx;
                out_sof   <= ld_first;
                ld_first  <= 1'b0;
                if (ld_cmd) begin
                    // command beat carries the row's first index, no advance
                    out_data <= row_cmd;
                    out_rs   <= 1'b0;
                    ld_cmd   <= 1'b0;
                end else begin
                    out_data <= ld_byte;
                    out_rs   <= 1'b1;
                    if (ld_idx == LAST_IDX) begin
                        ld_done <= 1'b1;
                    end else begin
                        ld_idx <= ld_idx + 6'd1;
                        if (ld_idx[3:0] == ROW_END) begin
                            ld_cmd <= 1'b1;
                        end
                    end
                end
            end else if (hs) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
            end
        end
    end
`else
    assign out_rs = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            ld_idx     <= '0;
            ld_done    <= 1'b0;
            ld_first   <= 1'b0;
        end else begin
            frame_done <= last_hs;
            if (frm_go) begin
                ld_idx   <= '0;
                ld_done  <= 1'b0;
                ld_first <= 1'b1;
            end else if (ld_fire) begin
                out_valid <= 1'b1;
                out_data  <= ld_byte;
                out_idx   <= ld_idx;
                out_sof   <= ld_first;
                ld_first  <= 1'b0;
                if (ld_idx == LAST_IDX) begin
                    ld_done <= 1'b1;
                end else begin
                    ld_idx <= ld_idx + 6'd1;
                end
            end else if (hs) begin
                // only reached once the final beat has been taken
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lcd12864_text_buf.sv
// Purpose : scoreboard bench for lcd12864_text_buf against a byte-array model.
// Latency : expected frame beats queued at request time, popped on each handshake.
// Backpress: out_ready driven always-1, 1-0-0 pattern, or random.

module tb_lcd12864_text_buf;

`ifdef LCD12864_TEXTBUF_ADDR_CMD_EN
    localparam int NB = 68;
`else
    localparam int NB = 64;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, put_en, cur_set, clr_req, frame_req, out_ready;
    logic [5:0] wr_addr, cur_addr;
    logic [7:0] wr_data, put_data;
    logic       busy, out_valid, out_rs, out_sof, frame_done;
    logic [5:0] cursor, out_idx;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    lcd12864_text_buf dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .put_en(put_en), .put_data(put_data),
        .cur_set(cur_set), .cur_addr(cur_addr),
        .clr_req(clr_req), .frame_req(frame_req),
        .busy(busy), .cursor(cursor),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_rs(out_rs),
        .out_sof(out_sof), .frame_done(frame_done)
    );

    typedef struct packed {
        logic       rs;
        logic       sof;
        logic [5:0] idx;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] mdl_mem [64];
    logic [5:0] mdl_cur;
    int n_cmp = 0;
    int n_err = 0;
    int frames_exp = 0;
    int fd_cnt = 0;
    int ready_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] row_addr(input int r);
        case (r)
            0: return 8'h80;
            1: return 8'h90;
            2: return 8'h88;
            default: return 8'h98;
        endcase
    endfunction

    // Expected frame in display order, from the model contents right now.
    task automatic push_frame();
        beat_t b;
        for (int r = 0; r < 4; r++) begin
`ifdef LCD12864_TEXTBUF_ADDR_CMD_EN
            b.rs = 1'b0; b.sof = (r == 0); b.idx = 6'(r * 16); b.data = row_addr(r);
            exp_q.push_back(b);
`endif
            for (int c = 0; c < 16; c++) begin
                b.rs = 1'b1;
`ifdef LCD12864_TEXTBUF_ADDR_CMD_EN
                b.sof = 1'b0;
`else
                b.sof = (r == 0 && c == 0);
`endif
                b.idx  = 6'(r * 16 + c);
                b.data = mdl_mem[r * 16 + c];
                exp_q.push_back(b);
            end
        end
        frames_exp++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mdl_mem[i] = 8'h20;
        mdl_cur = 6'd0;
    endtask

    // One cycle of application-port activity; model updated only when the
    // DUT is known to be idle (writes while clearing are dropped).
    task automatic op(input bit we, input logic [5:0] wa, input logic [7:0] wd,
                      input bit pe, input logic [7:0] pd,
                      input bit cs, input logic [5:0] ca, input bit model_en);
        logic [5:0] a;
        wr_en = we; wr_addr = wa; wr_data = wd;
        put_en = pe; put_data = pd; cur_set = cs; cur_addr = ca;
        if (model_en) begin
            if (we) mdl_mem[wa] = wd;
            if (pe) begin
                a = cs ? ca : mdl_cur;
                mdl_mem[a] = pd;
                mdl_cur = a + 6'd1;
            end else if (cs) begin
                mdl_cur = ca;
            end
        end
        step();
        wr_en = 1'b0; put_en = 1'b0; cur_set = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int cyc;
        cyc = 0;
        while (fd_cnt < target && cyc < budget) begin
            step();
            cyc++;
        end
        chk("frame_done_within_budget", int'(fd_cnt >= target), 1);
        step();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_frame();
        push_frame();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        wait_frames(frames_exp, 2000);
    endtask

    // out_ready driver
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pop on every handshake, and check stalled beats stay put.
    beat_t prev_b;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t cur_b;
        beat_t e;
        cur_b = {out_rs, out_sof, out_idx, out_data};
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid_held", int'(out_valid), 1);
                chk("stall_beat_held", int'(cur_b), int'(prev_b));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", int'(cur_b), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat{rs,sof,idx,data}", int'(cur_b), int'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_b     = cur_b;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && frame_done) fd_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        beat_t t;
        rst = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0; put_en = 0; put_data = 0;
        cur_set = 0; cur_addr = 0; clr_req = 0; frame_req = 0;
        model_clear();
        repeat (3) step();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_rs", out_rs, 1);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        step();

        // blank frame, full-rate; check frame_done latency and width
        ready_mode = 0;
        step();
        push_frame();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        cnt = 0;
        while (!frame_done && cnt < 300) begin
            step();
            cnt++;
        end
        chk("frame_done_latency", cnt, NB + 1);
        step();
        chk("frame_done_one_cycle", frame_done, 0);
        chk("out_valid_after_frame", out_valid, 0);
        step();
        chk("frames_after_first", fd_cnt, frames_exp);
        chk("queue_after_first", exp_q.size(), 0);

        // cursor printing
        op(0, 0, 0, 0, 0, 1, 6'd14, 1);
        op(0, 0, 0, 1, 8'h41, 0, 0, 1);
        op(0, 0, 0, 1, 8'h42, 0, 0, 1);
        op(0, 0, 0, 1, 8'h43, 0, 0, 1);
        chk("cursor_after_ABC", cursor, 17);
        op(0, 0, 0, 0, 0, 1, 6'd63, 1);
        op(0, 0, 0, 1, 8'h44, 0, 0, 1);
        op(0, 0, 0, 1, 8'h45, 0, 0, 1);
        chk("cursor_wrap", cursor, 1);
        // cur_set with put, colliding with a random-access write
        op(1, 6'd30, 8'h11, 1, 8'h99, 1, 6'd30, 1);
        chk("cursor_set_put", cursor, 31);
        ready_mode = 1;
        run_frame();

        // clear with writes attempted while busy
        op(1, 6'd5, 8'hE7, 0, 0, 0, 0, 1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        model_clear();
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            wr_en = (cnt == 10); wr_addr = 6'd9; wr_data = 8'h55;
            put_en = (cnt == 20); put_data = 8'h66;
            step();
        end
        wr_en = 1'b0; put_en = 1'b0;
        chk("busy_cycles", cnt, 64);
        chk("cursor_after_clear", cursor, 0);
        ready_mode = 2;
        run_frame();

        // clear and frame together, plus a repeat frame request while busy
        op(1, 6'd50, 8'h7A, 1, 8'h7B, 1, 6'd2, 1);
        clr_req = 1'b1; frame_req = 1'b1;
        step();
        clr_req = 1'b0; frame_req = 1'b0;
        model_clear();
        push_frame();
        repeat (5) step();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        wait_frames(frames_exp, 2000);
        repeat (150) step();
        chk("coalesced_frame_count", fd_cnt, frames_exp);

        // writes mid-stream with a queued second frame
        ready_mode = 0;
        push_frame();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        cnt = 0;
        while (!(out_valid && out_rs && out_idx == 6'd20) && cnt < 300) begin
            step();
            cnt++;
        end
        chk("reached_idx20", int'(cnt < 300), 1);
        wr_en = 1'b1; wr_addr = 6'd40; wr_data = 8'h31;
        put_en = 1'b1; put_data = 8'h32; cur_set = 1'b1; cur_addr = 6'd3;
        frame_req = 1'b1;
        mdl_mem[40] = 8'h31;
        mdl_mem[3]  = 8'h32;
        mdl_cur     = 6'd4;
        // beats after the one on the bus have not been loaded yet
        for (int i = 1; i < exp_q.size(); i++) begin
            t = exp_q[i];
            if (t.rs && t.idx == 6'd40) t.data = 8'h31;
            if (t.rs && t.idx == 6'd3)  t.data = 8'h32;
            exp_q[i] = t;
        end
        push_frame();
        step();
        wr_en = 1'b0; put_en = 1'b0; cur_set = 1'b0; frame_req = 1'b0;
        wait_frames(frames_exp, 2000);
        chk("cursor_after_midstream", cursor, 4);

        // randomized edits with random backpressure
        ready_mode = 2;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 24; k++) begin
                op(1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), 8'($urandom),
                   ($urandom_range(0, 3) == 0), 6'($urandom), 1);
            end
            chk("rand_cursor", cursor, mdl_cur);
            run_frame();
        end

        repeat (5) step();
        chk("total_frames", fd_cnt, frames_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd12864_text_buf.md
Name: lcd12864_text_buf

Overview:
- Upstream stage of the LCD12864 character driver.
- Holds a 4x16-byte text frame (ASCII, or GB2312 byte pairs) written by application logic through a random-access port or a cursor/"print" port.
- On request, streams the whole frame in display order over a valid/ready byte interface for the driver to send as DDRAM data.
- Also provides a sequential clear-screen operation.

Parameters:
- ROWS, 4, number of text rows; the index map below assumes 4.
- COLS, 16, bytes per row (8 CJK glyphs or 16 ASCII).
- CLR_CHAR, 8'h20, fill byte used by reset and by clear.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  random-access write strobe
- wr_addr  in  6  write index, row*16+col
- wr_data  in  8  write byte
- put_en  in  1  cursor write strobe
- put_data  in  8  byte written at the cursor
- cur_set  in  1  load cursor
- cur_addr  in  6  new cursor value
- clr_req  in  1  clear-screen request pulse
- frame_req  in  1  stream-frame request pulse
- busy  out  1  clear in progress
- cursor  out  6  current cursor index
- out_valid  out  1  stream byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  stream byte
- out_idx  out  6  index of out_data
- out_rs  out  1  1 = data byte, 0 = command byte
- out_sof  out  1  first beat of the frame
- frame_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Storage: 64x8 register array. Reset fills it with CLR_CHAR.
- Reset values: state IDLE, cursor=0, busy=0, out_valid=0, out_data=0, out_idx=0, out_rs=1, out_sof=0, frame_done=0, pending flags cleared.
- States: IDLE, CLEAR, STREAM.
- IDLE transitions:
  - clr_req or pending clear -> CLEAR. Clear has priority over frame.
  - else frame_req or pending frame -> STREAM.
- CLEAR:
  - busy=1; writes CLR_CHAR to index 0..63, one per cycle, for 64 cycles.
  - wr_en and put_en are ignored (dropped) while busy.
  - On the last write: cursor<=0, return to IDLE. busy falls the following cycle.
- STREAM:
  - Beats run for index 0..63 in order.
  - A beat loads when !out_valid || out_ready.
  - out_data, out_idx and out_sof hold stable while out_valid && !out_ready.
  - First out_valid appears 1 cycle after entering STREAM.
  - out_sof=1 only on the first beat.
  - frame_done pulses the cycle after the index-63 beat handshakes; the block then returns to IDLE (out_valid=0 that cycle).
- Writes during STREAM are allowed:
  - A write to an index not yet loaded appears in the stream.
  - A write in the same cycle as the load of that index is bypassed: the new byte is streamed.
- Requests arriving outside IDLE (or together with a clear) set a one-deep pending flag. Repeats coalesce. A pending clear runs before a pending frame.
- Cursor port:
  - put_en writes mem[cursor], then cursor+1, wrapping 63->0.
  - cur_set && put_en in the same cycle: write goes to cur_addr, cursor<=cur_addr+1.
  - cur_set alone: cursor<=cur_addr.
- wr_en and put_en to the same index in the same cycle: the put_en byte wins.
- Index arithmetic is 6-bit modulo 64.

Optional Feature:
- Macro: LCD12864_TEXTBUF_ADDR_CMD_EN.
- Defined:
  - Each row is preceded by a command beat with out_rs=0 and out_data = 8'h80, 8'h90, 8'h88, 8'h98 for rows 0..3.
  - The frame is 68 beats. out_idx of a command beat equals the row's first index.
  - out_sof marks the 8'h80 command beat.
- Undefined: out_rs is constant 1 and the frame is 64 data beats.

Test Plan:
- Reset, then frame_req with out_ready=1 -> 64 beats of 8'h20, out_sof on idx 0, frame_done exactly once, 65 cycles after frame_req.
- cur_set addr 14, then put_en "A","B","C" -> mem[14]="A", mem[15]="B", mem[16]="C", cursor=17. A second test with cur_addr=63 and two puts -> cursor wraps to 1.
- wr_en idx 5 = 8'hE7, then clr_req with wr_en to idx 9 during busy -> busy high 64 cycles, streamed frame is all 8'h20, cursor=0.
- Streaming with out_ready toggling 1,0,0,1,... -> no byte lost or duplicated; out_data stable whenever stalled.
- During STREAM at idx 20: write idx 40 = 8'h31 and idx 3 = 8'h32; also raise frame_req -> first frame shows 8'h31 at idx 40 and old data at idx 3; a second frame follows automatically with 8'h32 at idx 3.
- With LCD12864_TEXTBUF_ADDR_CMD_EN defined -> 68 beats; beats 0, 17, 34, 51 have out_rs=0 and data 80, 90, 88, 98.
